// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM state codes, reset PC,
// ack timeout default and PC increment.
package ifetch_pkg;
  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          MAX_WAIT_DEF = 15;
  localparam logic [31:0] PC_INC       = 32'd4;
endpackage

// File: rtl/ifetch_if.sv
// Instruction memory bus between ifetch (master) and the memory (slave).
interface ifetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, im_addr, input im_ack, im_rdata);
  modport slave  (input im_req, im_addr, output im_ack, im_rdata);
endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter register with +4 adder; load wins over inc, neither holds.
module pc_reg
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] load_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc + PC_INC;

  always_ff @(posedge clk) begin
    if (!rst)      pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc_plus4;
  end
endmodule

// File: rtl/ifetch.sv
// Instruction fetch FSM: REQ -> WAIT -> ISSUE (-> HOLD), sticky fault on ack timeout.
// Optional IFETCH_ALIGN_CHECK_EN turns a misaligned redirect target into a fault.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  ifetch_if.master        im,
  output logic            IRWr,
  output logic [31:0]     im_dout,
  output logic [31:0]     pc,
  output logic [31:0]     pc_plus4,
  output logic            fault
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [2:0]  state, nxt;
  logic [3:0]  wait_cnt;
  logic        pc_load, pc_inc, capture, set_fault, misalign;
  logic [31:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~32'd3;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = redirect_pc[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (redir_tgt),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // Gated by rst so the first request appears only once reset is released.
  assign im.im_req  = rst && (state == S_REQ || state == S_WAIT);
  assign im.im_addr = pc;
  assign IRWr       = (state == S_ISSUE);

  always_comb begin
    nxt       = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    set_fault = 1'b0;
    case (state)
      S_REQ:   nxt = S_WAIT;
      S_WAIT: begin
        if (im.im_ack) begin
          capture = 1'b1;
          nxt     = S_ISSUE;
        end else if (wait_cnt == MAX_W) begin
          set_fault = 1'b1;
          nxt       = S_ERR;
        end
      end
      S_ISSUE: begin
        pc_inc = 1'b1;
        nxt    = stall ? S_HOLD : S_REQ;
      end
      S_HOLD:  nxt = stall ? S_HOLD : S_REQ;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_REQ;
    endcase
    // Redirect overrides everything but ERR; IRWr in ISSUE is unaffected.
    if (redirect && state != S_ERR) begin
      capture   = 1'b0;
      pc_inc    = 1'b0;
      set_fault = misalign;
      pc_load   = !misalign;
      nxt       = misalign ? S_ERR : (stall ? S_HOLD : S_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_REQ;
      im_dout  <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (state == S_WAIT && nxt == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (capture)   im_dout <= im.im_rdata;
      if (set_fault) fault   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: expected issues queued per fetch, checked by an IRWr monitor.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        IRWr, fault;
  logic [31:0] im_dout, pc, pc_plus4;
  int          tests = 0;
  int          fails = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
  exp_t sb[$];

  ifetch_if m();

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im          (m),
    .IRWr        (IRWr),
    .im_dout     (im_dout),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (m.im_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, m.im_req}, 32'd1);
  endtask

  // Leaves the bench in the ISSUE cycle of this fetch.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
    exp_t e;
    wait_req("req_seen");
    chk("req_addr", m.im_addr, addr);
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
    cyc();
    repeat (delay) cyc();
    m.im_ack   = 1'b1;
    m.im_rdata = data;
    cyc();
    m.im_ack   = 1'b0;
    m.im_rdata = '0;
    chk("irwr_latency", {31'd0, IRWr}, 32'd1);
  endtask

  // Monitor: every IRWr strobe must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (IRWr === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_irwr: got strobe with dout %h at pc %h, expected none", im_dout, pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_dout", im_dout, e.data);
        chk("issue_pc", pc, e.addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m.im_ack = 1'b0; m.im_rdata = '0;
    cyc(); cyc();
    chk("rst_im_req", {31'd0, m.im_req}, 32'd0);
    chk("rst_irwr", {31'd0, IRWr}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
    chk("rst_dout", im_dout, 32'h0);

    // First fetch right after reset release
    rst = 1'b1;
    #1;
    chk("first_req", {31'd0, m.im_req}, 32'd1);
    fetch(32'h0000_3000, 32'h2001_0005, 0);
    cyc();
    chk("pc_after_issue", pc, 32'h0000_3004);

    // Redirect wins over a simultaneous ack
    wait_req("req_3004");
    chk("addr_3004", m.im_addr, 32'h0000_3004);
    cyc();
    m.im_ack = 1'b1; m.im_rdata = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 32'h0000_3100;
    cyc();
    m.im_ack = 1'b0; redirect = 1'b0;
    chk("redir_ack_irwr", {31'd0, IRWr}, 32'd0);
    chk("redir_ack_req", {31'd0, m.im_req}, 32'd1);
    chk("redir_ack_addr", m.im_addr, 32'h0000_3100);
    fetch(32'h0000_3100, 32'h1111_0001, 0);

    // Stall from ISSUE for 5 cycles: no requests, then resume at pc+4
    fetch(32'h0000_3104, 32'h2222_0002, 0);
    stall = 1'b1;
    chk("stall_req_0", {31'd0, m.im_req}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("stall_req", {31'd0, m.im_req}, 32'd0);
    end
    chk("stall_pc", pc, 32'h0000_3108);
    stall = 1'b0;

    // Ack on the last allowed WAIT cycle is accepted
    fetch(32'h0000_3108, 32'h3333_0003, 15);
    chk("late_ack_fault", {31'd0, fault}, 32'd0);

    // Redirect during ISSUE: strobe still happens, pc takes the target
    fetch(32'h0000_310C, 32'h4444_0004, 1);
    redirect = 1'b1; redirect_pc = 32'h0000_3200;
    cyc();
    redirect = 1'b0;
    fetch(32'h0000_3200, 32'h5555_0005, 0);

    // Misaligned redirect target
    wait_req("req_3204");
    redirect = 1'b1; redirect_pc = 32'h0000_3002;
    cyc();
    redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("misalign_fault", {31'd0, fault}, 32'd1);
    chk("misalign_req", {31'd0, m.im_req}, 32'd0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
`else
    chk("misalign_fault", {31'd0, fault}, 32'd0);
    fetch(32'h0000_3000, 32'h6666_0006, 0);
`endif

    // PC wraps past the top of the address space
    wait_req("req_pre_wrap");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h7777_0007, 0);
    cyc();
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_fault", {31'd0, fault}, 32'd0);
    wait_req("req_wrap");
    chk("wrap_addr", m.im_addr, 32'h0000_0000);

    // Reset mid-WAIT with an ack that must be dropped
    cyc();
    rst = 1'b0; m.im_ack = 1'b1; m.im_rdata = 32'hBAD0_BAD0;
    cyc();
    rst = 1'b1;
    cyc();
    m.im_ack = 1'b0;
    chk("post_rst_addr", m.im_addr, 32'h0000_3000);
    chk("post_rst_irwr", {31'd0, IRWr}, 32'd0);

    // Ack timeout: 16 WAIT cycles without ack -> ERR
    repeat (15) cyc();
    chk("to_fault_early", {31'd0, fault}, 32'd0);
    chk("to_req_early", {31'd0, m.im_req}, 32'd1);
    cyc();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req", {31'd0, m.im_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_3300; m.im_ack = 1'b1;
    cyc(); cyc();
    redirect = 1'b0; m.im_ack = 1'b0;
    chk("err_sticky_fault", {31'd0, fault}, 32'd1);
    chk("err_no_req", {31'd0, m.im_req}, 32'd0);
    chk("err_pc", pc, 32'h0000_3000);
    rst = 1'b0;
    cyc();
    chk("err_rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b1;
    #1;
    fetch(32'h0000_3000, 32'h8888_0008, 0);

    cyc(); cyc(); cyc();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-002 Parameter MAX_WAIT, default 15: the largest number of cycles that ifetch waits for im_ack before raising fault.
REQ-003 The following ports SHALL be provided (name, direction, width, meaning):
  clk         in   1   single clock, rising edge
  rst         in   1   reset, synchronous, active-low
  stall       in   1   hold after current fetch completes
  redirect    in   1   branch/jump taken, one-cycle pulse
  redirect_pc in   32  target PC
  im_req      out  1   instruction memory request
  im_addr     out  32  request address
  im_ack      in   1   memory data valid
  im_rdata    in   32  memory read data
  IRWr        out  1   one-cycle write strobe to instruction register
  im_dout     out  32  captured instruction, valid while IRWr=1
  pc          out  32  address of instruction in flight/last issued
  pc_plus4    out  32  pc+4
  fault       out  1   sticky fetch error

Function
REQ-004 The FSM SHALL have states REQ, WAIT, ISSUE, HOLD, ERR.
REQ-005 In REQ: im_req=1, im_addr=pc, and the next state SHALL be WAIT.
REQ-006 In WAIT: im_req=1 and im_addr=pc are held; on im_ack the block SHALL capture im_rdata and go to ISSUE.
REQ-007 In ISSUE: IRWr=1 for exactly one cycle with im_dout stable; pc<=pc+4; next state SHALL be HOLD if stall=1, else REQ.
REQ-008 In HOLD: no request is made; the FSM SHALL return to REQ in the cycle after stall deasserts.
REQ-009 Minimum fetch-to-strobe latency SHALL be 3 cycles (REQ, WAIT with ack, ISSUE); the steady-state issue rate SHALL be one per 3 cycles.
REQ-010 When redirect is asserted in any state except ERR: pc<=redirect_pc, any captured or in-flight data SHALL be discarded, no IRWr is generated, and the next state SHALL be REQ (HOLD if stall=1).
REQ-011 Redirect together with im_ack in WAIT: redirect SHALL win, the data is dropped, and IRWr stays 0.
REQ-012 Redirect in ISSUE: IRWr SHALL still pulse for the current instruction, and pc SHALL take redirect_pc rather than pc+4.
REQ-013 Redirect SHALL have priority over stall for the PC update; stall only selects the next state.
REQ-014 A WAIT-cycle counter (4 bits) SHALL run; exceeding MAX_WAIT SHALL set fault=1 and move the FSM to ERR.
REQ-015 ERR SHALL be terminal: im_req=0, IRWr=0, and redirect is ignored; only reset exits ERR.
REQ-016 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4=0) without flagging.
REQ-017 pc_plus4 SHALL be combinational, pc+4.

Reset
REQ-018 While rst=0 at a rising clk edge: pc=RESET_PC, state=REQ, im_dout=0, IRWr=0, fault=0, and the wait counter =0.
REQ-019 Reset mid-WAIT SHALL abandon the request; a late im_ack arriving after reset SHALL be ignored unless the FSM is in WAIT.
REQ-020 The first im_req SHALL assert in the first cycle after rst returns to 1.

Configuration
REQ-021 Macro IFETCH_ALIGN_CHECK_EN: when defined, a redirect_pc with bits[1:0]!=0 SHALL set fault and enter ERR instead of redirecting.
REQ-022 When IFETCH_ALIGN_CHECK_EN is undefined, redirect_pc[1:0] SHALL be forced to 0 and no fault is raised.

Structure
REQ-023 The shared package SHALL hold the FSM state enum, RESET_PC default, MAX_WAIT default, and the PC_INC constant (4).
REQ-024 The PC register and adder SHALL be a sub-module pc_reg (load, inc, hold controls); the FSM stays in ifetch.

Verification
REQ-025 Reset release, memory acks 1 cycle after req with 32'h2001_0005 -> im_addr=32'h0000_3000, IRWr pulses in cycle 3 with im_dout=32'h2001_0005, then pc=32'h0000_3004.
REQ-026 Redirect to 32'h0000_3100 in the same cycle as im_ack -> no IRWr, next im_addr=32'h0000_3100.
REQ-027 stall=1 during ISSUE held for 5 cycles -> im_req=0 for 5 cycles, then REQ at pc+4.
REQ-028 im_ack withheld for 16 cycles -> fault=1 and im_req=0 permanently; rst=0 then clears fault and fetches at RESET_PC.
REQ-029 pc=32'hFFFF_FFFC issued -> next im_addr=32'h0000_0000, fault=0.
REQ-030 Under IFETCH_ALIGN_CHECK_EN, redirect_pc=32'h0000_3002 -> fault=1 and ERR; without the macro -> fetch at 32'h0000_3000.
